// File: rtl/csi_param_pkg.sv
// Lane count and word geometry shared by the CSI receive path.
package csi_param_pkg;
  localparam int N_DATA_LANES         = 4;
  localparam int HS_RX_WORD_BIT_WIDTH = 8;
  localparam int SKEW_DEPTH           = 4;
endpackage

// File: rtl/csi_typedef_pkg.sv
// Bus types, adapter-layer FSM encoding and a strobe popcount helper.
package csi_typedef_pkg;
  import csi_param_pkg::*;

  typedef logic [N_DATA_LANES*HS_RX_WORD_BIT_WIDTH-1:0] t_data_lane_bus;
  typedef logic [N_DATA_LANES-1:0]                      t_data_lane_signal;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    RECEIVE = 2'd2,
    DRAIN   = 2'd3
  } t_rx_al_state;

  function automatic logic [15:0] lane_count(input logic [N_DATA_LANES-1:0] mask);
    logic [15:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_DATA_LANES; i++) cnt = cnt + 16'(mask[i]);
    return cnt;
  endfunction
endpackage

// File: rtl/d_phy_lane_deskew_fifo.sv
// Per-lane circular deskew buffer; read data is the head entry, valid while not empty.
module d_phy_lane_deskew_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             hs_rx_word_clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr, do_rd;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd && !empty;
  // A write into a full buffer is only accepted when the head leaves in the same cycle.
  assign do_wr   = wr && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge hs_rx_word_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= next_ptr(wr_ptr);
      if (do_rd) rd_ptr <= next_ptr(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge hs_rx_word_clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/d_phy_slave_adapter_layer.sv
// D-PHY receive adapter: deskews per-lane HS bytes and merges them into words for the CSI RX FIFO.
// state   | meaning
// IDLE    | no burst; waiting for the first lane sync
// SYNC    | lanes syncing one by one; bytes buffered, nothing popped
// RECEIVE | all lanes synced; full words popped while every buffer holds data
// DRAIN   | all lanes inactive; remaining tails popped as partial words
module d_phy_slave_adapter_layer
  import csi_param_pkg::*;
  import csi_typedef_pkg::*;
(
  input  logic                                         hs_rx_word_clk,
  input  logic                                         rst,
  input  logic [N_DATA_LANES-1:0]                      rx_active_hs,
  input  logic [N_DATA_LANES-1:0]                      rx_sync_hs,
  input  logic [N_DATA_LANES-1:0]                      rx_valid_hs,
  input  logic [N_DATA_LANES*HS_RX_WORD_BIT_WIDTH-1:0] rx_data_hs,
  input  logic [N_DATA_LANES:0]                        stop_state_lane,
  input  logic                                         fifo_full,
  output logic                                         push,
  output logic [N_DATA_LANES*HS_RX_WORD_BIT_WIDTH-1:0] push_data,
  output logic [N_DATA_LANES-1:0]                      push_strb,
  output logic                                         RxActiveHS,
  output logic                                         Stopstate,
  output logic                                         burst_done,
  output logic [15:0]                                  burst_bytes,
  output logic                                         err_skew,
  output logic                                         err_overflow
);
  localparam int N = N_DATA_LANES;
  localparam int W = HS_RX_WORD_BIT_WIDTH;

  t_rx_al_state      state, state_nxt;
  t_data_lane_signal synced, synced_nxt, pop_mask, lane_wr, lane_empty, lane_full;
  t_data_lane_bus    lane_rd_data, merged_data;
  logic              skew_hit, done_nxt, burst_start, acc_clr, pop_any, push_nxt;
  logic [15:0]       byte_acc;
  logic [16:0]       acc_sum;

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign lane_wr[g] = ((state == SYNC) || (state == RECEIVE)) && synced[g] &&
                        rx_valid_hs[g] && !skew_hit;

    d_phy_lane_deskew_fifo #(.DEPTH(SKEW_DEPTH), .WIDTH(W)) u_deskew (
      .hs_rx_word_clk (hs_rx_word_clk),
      .rst            (rst),
      .flush          (skew_hit),
      .wr             (lane_wr[g]),
      .wr_data        (rx_data_hs[g*W +: W]),
      .rd             (pop_mask[g]),
      .rd_data        (lane_rd_data[g*W +: W]),
      .empty          (lane_empty[g]),
      .full           (lane_full[g])
    );
  end

  always_comb begin
    state_nxt   = state;
    synced_nxt  = synced;
    skew_hit    = 1'b0;
    done_nxt    = 1'b0;
    burst_start = 1'b0;
    pop_mask    = '0;
    case (state)
      IDLE: begin
        if (|rx_sync_hs) begin
          state_nxt   = SYNC;
          synced_nxt  = rx_sync_hs;
          burst_start = 1'b1;
        end
      end
      SYNC: begin
        if (|lane_full) begin
          skew_hit   = 1'b1;
          synced_nxt = '0;
          state_nxt  = IDLE;
        end else begin
          synced_nxt = synced | rx_sync_hs;
          if (&synced) state_nxt = RECEIVE;
        end
      end
      RECEIVE: begin
        if (|lane_full && |lane_empty) begin
          skew_hit   = 1'b1;
          synced_nxt = '0;
          state_nxt  = IDLE;
        end else begin
          if (!(|lane_empty)) pop_mask = '1;
          if (!(|rx_active_hs)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // A fresh sync here means the previous burst never drained cleanly.
        if (|rx_sync_hs) begin
          skew_hit   = 1'b1;
          synced_nxt = rx_sync_hs;
          state_nxt  = SYNC;
        end else if (&lane_empty) begin
          done_nxt   = 1'b1;
          synced_nxt = '0;
          state_nxt  = IDLE;
        end else begin
          pop_mask = ~lane_empty;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    merged_data = '0;
    for (int i = 0; i < N; i++) begin
      if (pop_mask[i]) merged_data[i*W +: W] = lane_rd_data[i*W +: W];
    end
  end

  assign pop_any    = |pop_mask;
  assign push_nxt   = pop_any && !fifo_full;
  assign acc_clr    = burst_start || ((state == DRAIN) && skew_hit);
  assign acc_sum    = {1'b0, byte_acc} + {1'b0, lane_count(pop_mask)};
  assign RxActiveHS = (state != IDLE);

  always_ff @(posedge hs_rx_word_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      synced       <= '0;
      push         <= 1'b0;
      push_data    <= '0;
      push_strb    <= '0;
      Stopstate    <= 1'b0;
      burst_done   <= 1'b0;
      burst_bytes  <= '0;
      byte_acc     <= '0;
      err_skew     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      synced     <= synced_nxt;
      push       <= push_nxt;
      Stopstate  <= &stop_state_lane;
      burst_done <= done_nxt;
      if (push_nxt) begin
        push_data <= merged_data;
        push_strb <= pop_mask;
      end
      if (done_nxt) burst_bytes <= byte_acc;
      if (acc_clr) byte_acc <= '0;
      else if (push_nxt) byte_acc <= acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
      if (burst_start) begin
        err_skew     <= 1'b0;
        err_overflow <= 1'b0;
      end else begin
        if (skew_hit) err_skew <= 1'b1;
        if (pop_any && fifo_full) err_overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_d_phy_slave_adapter_layer.sv
// Scoreboard bench for the D-PHY receive adapter: expected words queued at stimulus time, checked on push.
module tb_d_phy_slave_adapter_layer;
  localparam int N = 4;

  typedef struct packed {
    logic [N*8-1:0] data;
    logic [N-1:0]   strb;
  } exp_t;

  logic           hs_rx_word_clk = 1'b0;
  logic           rst;
  logic [N-1:0]   rx_active_hs, rx_sync_hs, rx_valid_hs;
  logic [N*8-1:0] rx_data_hs;
  logic [N:0]     stop_state_lane;
  logic           fifo_full;
  logic           push;
  logic [N*8-1:0] push_data;
  logic [N-1:0]   push_strb;
  logic           RxActiveHS, Stopstate, burst_done, err_skew, err_overflow;
  logic [15:0]    burst_bytes;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          first_push_cyc = -1;
  int          done_cnt = 0;
  int          push_cnt = 0;
  logic [15:0] done_bytes = '0;
  int          full_lo = -1;
  int          full_hi = -1;
  int          lane_dly [N];
  int          lane_len [N];
  exp_t        exp_q [$];

  d_phy_slave_adapter_layer dut (
    .hs_rx_word_clk  (hs_rx_word_clk),
    .rst             (rst),
    .rx_active_hs    (rx_active_hs),
    .rx_sync_hs      (rx_sync_hs),
    .rx_valid_hs     (rx_valid_hs),
    .rx_data_hs      (rx_data_hs),
    .stop_state_lane (stop_state_lane),
    .fifo_full       (fifo_full),
    .push            (push),
    .push_data       (push_data),
    .push_strb       (push_strb),
    .RxActiveHS      (RxActiveHS),
    .Stopstate       (Stopstate),
    .burst_done      (burst_done),
    .burst_bytes     (burst_bytes),
    .err_skew        (err_skew),
    .err_overflow    (err_overflow)
  );

  always #5 hs_rx_word_clk = ~hs_rx_word_clk;

  always @(posedge hs_rx_word_clk) cyc <= cyc + 1;

  always @(negedge hs_rx_word_clk) begin : mon
    exp_t e;
    if (push === 1'b1) begin
      push_cnt++;
      if (first_push_cyc < 0) first_push_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_push: got data=%h strb=%b, expected no push", push_data, push_strb);
      end else begin
        e = exp_q.pop_front();
        if (push_data !== e.data || push_strb !== e.strb) begin
          n_fail++;
          $display("FAIL push_word: got data=%h strb=%b, expected data=%h strb=%b",
                   push_data, push_strb, e.data, e.strb);
        end
      end
    end
    if (burst_done === 1'b1) begin
      done_cnt++;
      done_bytes = burst_bytes;
      n_checks++;
      if (RxActiveHS !== 1'b0) begin
        n_fail++;
        $display("FAIL rxactive_at_done: got %b, expected 0", RxActiveHS);
      end
    end
  end

  task automatic idle_inputs();
    rx_active_hs = '0;
    rx_sync_hs   = '0;
    rx_valid_hs  = '0;
    rx_data_hs   = '0;
    fifo_full    = 1'b0;
  endtask

  task automatic set_lanes(input int d0, d1, d2, d3, l0, l1, l2, l3);
    lane_dly[0] = d0; lane_dly[1] = d1; lane_dly[2] = d2; lane_dly[3] = d3;
    lane_len[0] = l0; lane_len[1] = l1; lane_len[2] = l2; lane_len[3] = l3;
  endtask

  // Lane i sends sync at cycle dly, then len bytes base+4k+i; returns early with rst high at abort_at.
  task automatic run_burst(input logic [7:0] base, input bit expect_push, input int abort_at);
    int   maxd, maxl, t_end, d0, p0, exp_bytes, lat, pop_c;
    exp_t e;
    maxd = 0; maxl = 0; t_end = 0; exp_bytes = 0;
    for (int i = 0; i < N; i++) begin
      if (lane_dly[i] > maxd) maxd = lane_dly[i];
      if (lane_len[i] > maxl) maxl = lane_len[i];
      if (lane_dly[i] + lane_len[i] > t_end) t_end = lane_dly[i] + lane_len[i];
    end
    if (expect_push) begin
      for (int k = 0; k < maxl; k++) begin
        e.strb = '0;
        e.data = '0;
        for (int i = 0; i < N; i++) begin
          if (lane_len[i] > k) begin
            e.strb[i] = 1'b1;
            e.data[i*8 +: 8] = 8'(int'(base) + 4*k + i);
          end
        end
        pop_c = maxd + 2 + k;
        if (!((&e.strb) && pop_c >= full_lo && pop_c < full_hi)) begin
          exp_q.push_back(e);
          for (int i = 0; i < N; i++) exp_bytes += int'(e.strb[i]);
        end
      end
    end
    d0 = done_cnt;
    p0 = push_cnt;
    first_push_cyc = -1;
    for (int c = 0; c <= t_end; c++) begin
      for (int i = 0; i < N; i++) begin
        rx_sync_hs[i]   = (c == lane_dly[i]);
        rx_valid_hs[i]  = (c > lane_dly[i]) && (c <= lane_dly[i] + lane_len[i]);
        rx_active_hs[i] = (c >= lane_dly[i]) && (c <= lane_dly[i] + lane_len[i]);
        rx_data_hs[i*8 +: 8] = rx_valid_hs[i] ? 8'(int'(base) + 4*(c - lane_dly[i] - 1) + i) : 8'h00;
      end
      fifo_full = (c >= full_lo) && (c < full_hi);
      @(posedge hs_rx_word_clk); #1;
      if (c == 0) start_cyc = cyc;
      if (c == abort_at) begin
        #2 rst = 1'b1;
        return;
      end
    end
    idle_inputs();
    if (expect_push) begin
      for (int w = 0; w < 60 && done_cnt == d0; w++) @(negedge hs_rx_word_clk);
      @(negedge hs_rx_word_clk);
      n_checks++;
      if (done_cnt != d0 + 1) begin
        n_fail++;
        $display("FAIL burst_done_count: got %0d pulses, expected 1 (timeout bound 60 cycles)", done_cnt - d0);
      end
      n_checks++;
      if (done_bytes !== 16'(exp_bytes)) begin
        n_fail++;
        $display("FAIL burst_bytes: got %0d, expected %0d", done_bytes, exp_bytes);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_pushes: %0d expected words never pushed", exp_q.size());
        exp_q.delete();
      end
      lat = first_push_cyc - start_cyc;
      n_checks++;
      if (lat != maxd + 2) begin
        n_fail++;
        $display("FAIL first_push_latency: got %0d cycles after sync, expected %0d", lat, maxd + 2);
      end
    end else begin
      repeat (20) @(negedge hs_rx_word_clk);
      n_checks++;
      if (push_cnt != p0) begin
        n_fail++;
        $display("FAIL no_push_expected: got %0d pushes, expected 0", push_cnt - p0);
      end
      n_checks++;
      if (done_cnt != d0) begin
        n_fail++;
        $display("FAIL no_done_expected: got %0d pulses, expected 0", done_cnt - d0);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({push, push_data, push_strb, RxActiveHS, Stopstate, burst_done, burst_bytes, err_skew, err_overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got push=%b data=%h strb=%b act=%b stop=%b done=%b bytes=%h skew=%b ovf=%b, expected all 0",
               push, push_data, push_strb, RxActiveHS, Stopstate, burst_done, burst_bytes, err_skew, err_overflow);
    end
    @(posedge hs_rx_word_clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_stopstate();
    stop_state_lane = 5'h1F;
    #1;
    n_checks++;
    if (Stopstate !== 1'b0) begin
      n_fail++;
      $display("FAIL stopstate_lag: got %b before edge, expected 0", Stopstate);
    end
    @(posedge hs_rx_word_clk); #1;
    n_checks++;
    if (Stopstate !== 1'b1) begin
      n_fail++;
      $display("FAIL stopstate_set: got %b, expected 1", Stopstate);
    end
    stop_state_lane = 5'h17;
    @(posedge hs_rx_word_clk); #1;
    n_checks++;
    if (Stopstate !== 1'b0) begin
      n_fail++;
      $display("FAIL stopstate_clear: got %b with lane 3 out of stop, expected 0", Stopstate);
    end
    stop_state_lane = '0;
  endtask

  task automatic test_aligned();
    set_lanes(0, 0, 0, 0, 8, 8, 8, 8);
    run_burst(8'h00, 1'b1, -1);
    n_checks++;
    if ({err_skew, err_overflow} !== 2'b00) begin
      n_fail++;
      $display("FAIL aligned_errors: got skew=%b ovf=%b, expected 0 0", err_skew, err_overflow);
    end
  endtask

  task automatic test_lane_skew_tolerated();
    set_lanes(0, 0, 2, 0, 4, 4, 4, 4);
    run_burst(8'h40, 1'b1, -1);
    n_checks++;
    if (err_skew !== 1'b0) begin
      n_fail++;
      $display("FAIL skew_tolerated_err: got err_skew=%b, expected 0", err_skew);
    end
  endtask

  task automatic test_skew_error();
    set_lanes(0, 0, 0, 4, 4, 4, 4, 4);
    run_burst(8'h60, 1'b0, -1);
    n_checks++;
    if (err_skew !== 1'b1) begin
      n_fail++;
      $display("FAIL skew_error_flag: got err_skew=%b, expected 1", err_skew);
    end
    n_checks++;
    if (RxActiveHS !== 1'b0) begin
      n_fail++;
      $display("FAIL skew_error_idle: got RxActiveHS=%b, expected 0", RxActiveHS);
    end
    set_lanes(0, 0, 0, 0, 2, 2, 2, 2);
    run_burst(8'h80, 1'b1, -1);
    n_checks++;
    if (err_skew !== 1'b0) begin
      n_fail++;
      $display("FAIL skew_error_cleared: got err_skew=%b after new burst, expected 0", err_skew);
    end
  endtask

  task automatic test_partial_tail();
    set_lanes(0, 0, 0, 0, 5, 5, 4, 4);
    run_burst(8'h20, 1'b1, -1);
  endtask

  task automatic test_overflow();
    full_lo = 3;
    full_hi = 5;
    set_lanes(0, 0, 0, 0, 6, 6, 6, 6);
    run_burst(8'hC0, 1'b1, -1);
    full_lo = -1;
    full_hi = -1;
    n_checks++;
    if (err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flag: got err_overflow=%b, expected 1", err_overflow);
    end
  endtask

  task automatic test_reset_mid_burst();
    int d0;
    set_lanes(0, 0, 0, 0, 8, 8, 8, 8);
    run_burst(8'hE0, 1'b1, 4);
    #1;
    n_checks++;
    if ({push, push_data, push_strb, RxActiveHS, Stopstate, burst_done, burst_bytes, err_skew, err_overflow} !== '0) begin
      n_fail++;
      $display("FAIL mid_burst_reset: got push=%b data=%h strb=%b act=%b stop=%b done=%b bytes=%h skew=%b ovf=%b, expected all 0",
               push, push_data, push_strb, RxActiveHS, Stopstate, burst_done, burst_bytes, err_skew, err_overflow);
    end
    exp_q.delete();
    idle_inputs();
    d0 = done_cnt;
    @(posedge hs_rx_word_clk); #1;
    rst = 1'b0;
    repeat (20) @(negedge hs_rx_word_clk);
    n_checks++;
    if (done_cnt != d0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d burst_done pulses, expected 0", done_cnt - d0);
    end
    set_lanes(0, 0, 0, 0, 8, 8, 8, 8);
    run_burst(8'hA0, 1'b1, -1);
  endtask

  initial begin
    rst = 1'b1;
    stop_state_lane = '0;
    idle_inputs();
    test_reset();
    test_stopstate();
    test_aligned();
    test_lane_skew_tolerated();
    test_skew_error();
    test_partial_tail();
    test_overflow();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
